// File: rtl/bk_mp_addsub_seq.sv
// Multi-precision add/subtract sequencer: one 16-bit limb per clock,
// LSB limb first, carry chained through a register into a Brent-Kung core.

module bk_add16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] gg;
    logic [15:0] pp;

    always_comb begin
        g = x & y;
        p = x ^ y;
        gg = g;
        pp = p;
        gg[0] = g[0] | (p[0] & cin);
        // up-sweep builds prefixes at 2^k-1, down-sweep fills the gaps
        for (int d = 1; d < 16; d = d * 2) begin
            for (int i = d; i < 16; i++) begin
                if ((i + 1) % (2 * d) == 0) begin
                    gg[i] = gg[i] | (pp[i] & gg[i-d]);
                    pp[i] = pp[i] & pp[i-d];
                end
            end
        end
        for (int d = 4; d > 0; d = d / 2) begin
            for (int i = d; i < 16; i++) begin
                if (((i + 1) % (2 * d) == d) && (i >= 2 * d)) begin
                    gg[i] = gg[i] | (pp[i] & gg[i-d]);
                    pp[i] = pp[i] & pp[i-d];
                end
            end
        end
        sum = p ^ {gg[14:0], cin};
        cout = gg[15];
    end
endmodule

module bk_mp_addsub_seq #(
    parameter int WORDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              op_sub,
    input  logic [16*WORDS-1:0] a,
    input  logic [16*WORDS-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [16*WORDS-1:0] result,
    output logic              cout,
    output logic              ovf
);
    localparam int W = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  res_q;
    logic          cout_q;
    logic          ovf_q;
    logic [15:0]   a_limb;
    logic [15:0]   b_limb;
    logic [15:0]   sum;
    logic          c_out;

    assign a_limb = a_q[16*idx +: 16];
    assign b_limb = b_q[16*idx +: 16];

    bk_add16 u_add (
        .x    (a_limb),
        .y    (b_limb),
        .cin  (carry),
        .sum  (sum),
        .cout (c_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= op_sub ? ~b : b;
                        carry <= op_sub;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res_q[16*idx +: 16] <= sum;
                    carry <= c_out;
                    if (idx == LAST) begin
                        cout_q <= c_out;
                        // sign overflow: like-signed operands, differing result sign
                        ovf_q  <= (a_limb[15] == b_limb[15]) &&
                                  (sum[15] != a_limb[15]);
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = res_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule
